// File: rtl/clk_wiz_ctrl.sv
// Sequencer for the ip_clk_wiz clocking block: pulses the wizard reset, waits for
// lock with timeout and bounded retries, then releases downstream reset after a settle window.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RESET_WIZ | wizard held in reset for RST_HOLD_CYCLES
// WAIT_LOCK | wizard running, waiting for synchronized lock
// SETTLE    | lock seen, must stay high for SETTLE_CYCLES
// RUN       | downstream released, watching for lock loss
// FAIL      | retries exhausted, wizard held in reset until restart
module clk_wiz_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned SETTLE_CYCLES   = 1024,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned TIMER_W         = 24
) (
    input  logic       i_clk,
    input  logic       i_sys_rst,
    input  logic       i_locked,
    input  logic       i_restart_req,
    output logic       o_wiz_rst,
    output logic       o_rst_n_out,
    output logic       o_sys_ready,
    output logic       o_fail,
    output logic [3:0] o_retry_cnt,
    output logic [7:0] o_lock_loss_cnt,
    output logic [2:0] o_state_dbg
);

    typedef enum logic [2:0] {
        ST_RESET_WIZ = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Timer holds (cycles spent in state - 1) just before the leaving edge.
    localparam logic [TIMER_W-1:0] HOLD_TC   = TIMER_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_TC     = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_TC = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]         RETRY_MAX = 4'(MAX_RETRY);

    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_sync1;
    logic               r_sync2;
    logic [3:0]         r_retry;
    logic [7:0]         r_lloss;
    logic               r_wiz_rst;
    logic               r_rst_n;
    logic               r_ready;
    logic               r_fail;

    state_t             w_state_nxt;
    logic               w_fail_path;
    logic               w_timer_clr;
    logic [3:0]         w_retry_nxt;
    logic [7:0]         w_lloss_nxt;
    logic               w_wiz_rst_nxt;
    logic               w_rst_n_nxt;
    logic               w_ready_nxt;
    logic               w_fail_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_sys_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_locked;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_lloss_nxt = r_lloss;
        w_fail_path = 1'b0;
        if (i_restart_req) begin
            w_state_nxt = ST_RESET_WIZ;
            w_retry_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_RESET_WIZ: begin
                    if (r_timer == HOLD_TC) w_state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (r_sync2)               w_state_nxt = ST_SETTLE;
                    else if (r_timer == TO_TC) w_fail_path = 1'b1;
                end
                ST_SETTLE: begin
                    if (!r_sync2) begin
                        w_fail_path = 1'b1;
                    end else if (r_timer == SETTLE_TC) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = 4'd0;
                    end
                end
                ST_RUN: begin
                    // Lock loss in RUN restarts the wizard without spending a retry.
                    if (!r_sync2) begin
                        w_state_nxt = ST_RESET_WIZ;
                        if (r_lloss != 8'hFF) w_lloss_nxt = r_lloss + 8'd1;
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_RESET_WIZ;
                end
            endcase
            if (w_fail_path) begin
                if (r_retry == RETRY_MAX) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_state_nxt = ST_RESET_WIZ;
                    w_retry_nxt = r_retry + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_timer_clr   = i_restart_req || (w_state_nxt != r_state);
        w_wiz_rst_nxt = (w_state_nxt == ST_RESET_WIZ) || (w_state_nxt == ST_FAIL);
        w_rst_n_nxt   = (w_state_nxt == ST_RUN);
        w_ready_nxt   = (w_state_nxt == ST_RUN);
        w_fail_nxt    = (w_state_nxt == ST_FAIL);
    end

    always_ff @(posedge i_clk) begin
        if (!i_sys_rst) begin
            r_state   <= ST_RESET_WIZ;
            r_timer   <= '0;
            r_retry   <= 4'd0;
            r_lloss   <= 8'd0;
            r_wiz_rst <= 1'b1;
            r_rst_n   <= 1'b0;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_retry   <= w_retry_nxt;
            r_lloss   <= w_lloss_nxt;
            r_wiz_rst <= w_wiz_rst_nxt;
            r_rst_n   <= w_rst_n_nxt;
            r_ready   <= w_ready_nxt;
            r_fail    <= w_fail_nxt;
            // Saturate so long stays in RUN/FAIL never wrap into a false terminal count.
            if (w_timer_clr)          r_timer <= '0;
            else if (r_timer != '1)   r_timer <= r_timer + 1'b1;
        end
    end

    assign o_wiz_rst       = r_wiz_rst;
    assign o_rst_n_out     = r_rst_n;
    assign o_sys_ready     = r_ready;
    assign o_fail          = r_fail;
    assign o_retry_cnt     = r_retry;
    assign o_lock_loss_cnt = r_lloss;
    assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_clk_wiz_ctrl.sv
// Scoreboard bench for clk_wiz_ctrl: an edge-level reference model predicts every
// output after each clock edge; a monitor pops and compares independently.
module tb_clk_wiz_ctrl;

    localparam int HOLD = 4;
    localparam int TO   = 20;
    localparam int SET  = 8;
    localparam int MAXR = 2;

    localparam int S_RW   = 0;
    localparam int S_WL   = 1;
    localparam int S_ST   = 2;
    localparam int S_RUN  = 3;
    localparam int S_FAIL = 4;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       wiz_rst, rst_n_out, sys_ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    clk_wiz_ctrl #(
        .RST_HOLD_CYCLES(HOLD),
        .LOCK_TIMEOUT   (TO),
        .SETTLE_CYCLES  (SET),
        .MAX_RETRY      (MAXR),
        .TIMER_W        (24)
    ) dut (
        .i_clk          (clk),
        .i_sys_rst      (sys_rst),
        .i_locked       (locked),
        .i_restart_req  (restart_req),
        .o_wiz_rst      (wiz_rst),
        .o_rst_n_out    (rst_n_out),
        .o_sys_ready    (sys_ready),
        .o_fail         (fail),
        .o_retry_cnt    (retry_cnt),
        .o_lock_loss_cnt(lock_loss_cnt),
        .o_state_dbg    (state_dbg)
    );

    typedef struct packed {
        logic       wiz_rst;
        logic       rst_n;
        logic       ready;
        logic       fail;
        logic [3:0] retry;
        logic [7:0] lloss;
        logic [2:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   exp_edge_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: state plus the edge number it was entered on.
    int edge_n   = -1;
    int last_rst = -100;
    int m_state  = S_RW;
    int m_entry  = 0;
    int m_retry  = 0;
    int m_lloss  = 0;
    bit samp[$];

    function automatic bit lock_seen(int n);
        if (n - 2 <= last_rst || n < 2) return 1'b0;
        return samp[n - 2];
    endfunction

    function automatic void fail_path();
        if (m_retry == MAXR) begin
            m_state = S_FAIL;
        end else begin
            m_retry = m_retry + 1;
            m_state = S_RW;
        end
        m_entry = edge_n;
    endfunction

    function automatic obs_t model_step(bit rst, bit rr, bit lk);
        obs_t o;
        int   el;
        bit   ls;
        edge_n = edge_n + 1;
        samp.push_back(lk);
        if (!rst) begin
            m_state  = S_RW;
            m_entry  = edge_n;
            m_retry  = 0;
            m_lloss  = 0;
            last_rst = edge_n;
        end else if (rr) begin
            m_state = S_RW;
            m_entry = edge_n;
            m_retry = 0;
        end else begin
            el = edge_n - m_entry;
            ls = lock_seen(edge_n);
            case (m_state)
                S_RW: if (el >= HOLD) begin m_state = S_WL; m_entry = edge_n; end
                S_WL: begin
                    if (ls) begin m_state = S_ST; m_entry = edge_n; end
                    else if (el >= TO) fail_path();
                end
                S_ST: begin
                    if (!ls) fail_path();
                    else if (el >= SET) begin m_state = S_RUN; m_entry = edge_n; m_retry = 0; end
                end
                S_RUN: if (!ls) begin
                    m_lloss = (m_lloss >= 255) ? 255 : m_lloss + 1;
                    m_state = S_RW;
                    m_entry = edge_n;
                end
                default: ;
            endcase
        end
        o.wiz_rst = (m_state == S_RW) || (m_state == S_FAIL);
        o.rst_n   = (m_state == S_RUN);
        o.ready   = (m_state == S_RUN);
        o.fail    = (m_state == S_FAIL);
        o.retry   = 4'(m_retry);
        o.lloss   = 8'(m_lloss);
        o.st      = 3'(m_state);
        return o;
    endfunction

    initial begin : monitor
        obs_t e;
        obs_t a;
        int   en;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                en = exp_edge_q.pop_front();
                a  = {wiz_rst, rst_n_out, sys_ready, fail, retry_cnt, lock_loss_cnt, state_dbg};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard edge %0d: got wiz=%b rstn=%b rdy=%b fail=%b retry=%0d lloss=%0d st=%0d, want wiz=%b rstn=%b rdy=%b fail=%b retry=%0d lloss=%0d st=%0d",
                             en, a.wiz_rst, a.rst_n, a.ready, a.fail, a.retry, a.lloss, a.st,
                             e.wiz_rst, e.rst_n, e.ready, e.fail, e.retry, e.lloss, e.st);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    task automatic tick(bit rst, bit rr, bit lk);
        @(negedge clk);
        sys_rst     = rst;
        restart_req = rr;
        locked      = lk;
        exp_q.push_back(model_step(rst, rr, lk));
        exp_edge_q.push_back(edge_n);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(string name, int target, int maxc, bit lk);
        int k = 0;
        while (state_dbg !== 3'(target) && k < maxc) begin
            tick(1'b1, 1'b0, lk);
            k++;
        end
        chk(name, 32'(state_dbg), target);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  run_left;
        bit  lk;
        bit  rst;
        bit  rr;

        // 1. normal bring-up; rel edge 0 is the last edge sampling reset
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        chk("rst wiz_rst", 32'(wiz_rst), 1);
        chk("rst rst_n_out", 32'(rst_n_out), 0);
        chk("rst sys_ready", 32'(sys_ready), 0);
        chk("rst fail", 32'(fail), 0);
        chk("rst state", 32'(state_dbg), S_RW);
        for (int r = 1; r <= 20; r++) begin
            tick(1'b1, 1'b0, r >= 10);
            if (r == 3)  chk("bringup wiz_rst@3", 32'(wiz_rst), 1);
            if (r == 4)  chk("bringup wiz_rst@4", 32'(wiz_rst), 0);
            if (r == 4)  chk("bringup state@4", 32'(state_dbg), S_WL);
            if (r == 11) chk("bringup state@11", 32'(state_dbg), S_WL);
            if (r == 12) chk("bringup state@12", 32'(state_dbg), S_ST);
            if (r == 19) chk("bringup ready@19", 32'(sys_ready), 0);
            if (r == 20) chk("bringup ready@20", 32'(sys_ready), 1);
            if (r == 20) chk("bringup rst_n@20", 32'(rst_n_out), 1);
            if (r == 20) chk("bringup retry@20", 32'(retry_cnt), 0);
        end

        // 2. timeouts and retries to FAIL
        tick(1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 100; r++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (r == 23) chk("timeout state@23", 32'(state_dbg), S_WL);
            if (r == 24) chk("timeout retry@24", 32'(retry_cnt), 1);
            if (r == 24) chk("timeout state@24", 32'(state_dbg), S_RW);
            if (r == 48) chk("timeout retry@48", 32'(retry_cnt), 2);
            if (r == 72) chk("timeout state@72", 32'(state_dbg), S_FAIL);
            if (r == 72) chk("timeout fail@72", 32'(fail), 1);
            if (r == 72) chk("timeout wiz_rst@72", 32'(wiz_rst), 1);
            if (r == 100) chk("fail hold@100", 32'(state_dbg), S_FAIL);
        end

        // 3. recovery from FAIL
        tick(1'b1, 1'b1, 1'b1);
        chk("restart state", 32'(state_dbg), S_RW);
        chk("restart retry", 32'(retry_cnt), 0);
        chk("restart fail", 32'(fail), 0);
        wait_state("recover to RUN", S_RUN, 40, 1'b1);

        // 4. lock drop during SETTLE
        tick(1'b1, 1'b1, 1'b1);
        wait_state("reach SETTLE", S_ST, 20, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        wait_state("settle drop", S_RW, 10, 1'b0);
        chk("settle drop retry", 32'(retry_cnt), 1);
        wait_state("settle retry RUN", S_RUN, 60, 1'b1);
        chk("settle retry cleared", 32'(retry_cnt), 0);

        // 5. lock loss in RUN, then saturation
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("loss ready still high", 32'(sys_ready), 1);
        tick(1'b1, 1'b0, 1'b0);
        chk("loss ready", 32'(sys_ready), 0);
        chk("loss rst_n", 32'(rst_n_out), 0);
        chk("loss count", 32'(lock_loss_cnt), 1);
        chk("loss retry", 32'(retry_cnt), 0);
        for (int i = 0; i < 299; i++) begin
            wait_state("loss loop RUN", S_RUN, 60, 1'b1);
            repeat (3) tick(1'b1, 1'b0, 1'b0);
        end
        chk("loss saturate", 32'(lock_loss_cnt), 255);

        // 6. reset beats restart; restart alone keeps lock_loss_cnt
        wait_state("prio SETTLE", S_ST, 30, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk("prio state", 32'(state_dbg), S_RW);
        chk("prio wiz_rst", 32'(wiz_rst), 1);
        chk("prio lloss", 32'(lock_loss_cnt), 0);
        wait_state("prio RUN", S_RUN, 40, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        wait_state("prio RUN2", S_RUN, 60, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("restart in RUN state", 32'(state_dbg), S_RW);
        chk("restart in RUN lloss", 32'(lock_loss_cnt), 1);
        chk("restart in RUN ready", 32'(sys_ready), 0);

        // random phase
        run_left = 0;
        lk = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                lk = ~lk;
                run_left = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
            end
            run_left--;
            rst = ($urandom_range(0, 299) != 0);
            rr  = ($urandom_range(0, 199) == 0);
            tick(rst, rr, lk);
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_wiz_ctrl.md
Name: clk_wiz_ctrl

Overview:
Supervisor/sequencer for the ip_clk_wiz clocking block. It drives the clock-wizard reset and watches its locked flag, retrying with a timeout and a bounded retry count. Once lock has been stable for a settle window, it releases a synchronous active-low reset and a ready flag to downstream logic. Runs on the board input clock, not on a wizard output clock.

Parameters:
RST_HOLD_CYCLES, 16, cycles wiz_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before the attempt counts as failed (>=1)
SETTLE_CYCLES, 1024, consecutive cycles of lock required before release (>=1)
MAX_RETRY, 3, failed attempts tolerated before FAIL (0..15)
TIMER_W, 24, timer width; all cycle parameters must fit in TIMER_W bits

Ports:
clk  input  1  board input clock; sole clock domain
sys_rst  input  1  synchronous, active-low reset
locked  input  1  wizard lock flag, asynchronous to clk
restart_req  input  1  single-cycle request to restart sequencing from scratch
wiz_rst  output  1  active-high reset to the clock wizard
rst_n_out  output  1  synchronous active-low reset to downstream logic
sys_ready  output  1  high only in RUN
fail  output  1  high only in FAIL
retry_cnt  output  4  failed attempts since the last RUN or restart
lock_loss_cnt  output  8  lock drops seen while in RUN; saturates at 255
state_dbg  output  3  current state encoding

Behaviour:
- Reset: one clock, reset synchronous active-low on sys_rst.
- While sys_rst=0: state=RESET_WIZ, timer=0, wiz_rst=1, rst_n_out=0, sys_ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0, sync flops=0.
- Reset mid-operation forces these values at the next edge.
- locked passes through a 2-flop synchronizer to give locked_s. If edge N is the first edge to sample locked=1, locked_s is visible to the FSM at edge N+2.
- All outputs are registered and decoded from the next state, so they change at the same edge as the state.
- Timer clears on every state entry and increments every cycle within a state.
- State encoding: RESET_WIZ=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAIL=4.
- RESET_WIZ: wiz_rst=1, rst_n_out=0.
  - Entered at edge E; moves to WAIT_LOCK at edge E+RST_HOLD_CYCLES.
  - locked is ignored in this state.
- WAIT_LOCK: wiz_rst=0, rst_n_out=0.
  - If locked_s=1, move to SETTLE at that edge.
  - Otherwise, at edge W+LOCK_TIMEOUT (W = entry edge), take the failure path.
- SETTLE: wiz_rst=0, rst_n_out=0.
  - If locked_s=0 on any edge, take the failure path.
  - If locked_s stays 1, move to RUN at edge S+SETTLE_CYCLES (S = entry edge).
- RUN: rst_n_out=1, sys_ready=1, retry_cnt cleared to 0 on entry.
  - locked_s=0 → lock_loss_cnt increments (saturating), go to RESET_WIZ. rst_n_out=0 and sys_ready=0 at the same edge.
  - A lock loss in RUN does not consume a retry.
- Failure path:
  - retry_cnt==MAX_RETRY → go to FAIL.
  - Otherwise retry_cnt+1 and go to RESET_WIZ.
- FAIL: wiz_rst=1, rst_n_out=0, fail=1. Stays in FAIL until restart_req.
- Priority at each edge: sys_rst=0 > restart_req > state transitions.
- restart_req=1 in any state → RESET_WIZ with timer=0 and retry_cnt=0. lock_loss_cnt is preserved.
  - In RESET_WIZ this restarts the hold count.
- A locked glitch shorter than one clk may be missed; this is accepted behaviour.
- States 5..7 are unreachable; if entered, go to RESET_WIZ on the next edge.

Test Plan:
Bench parameters: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRY=2.

1. Normal bring-up: release sys_rst at edge 0 → wiz_rst=1 for edges 0..3, low from edge 4. Drive locked=1 sampled first at edge 10 → SETTLE at edge 12, sys_ready=1 and rst_n_out=1 at edge 20, retry_cnt=0.
2. Timeout and retries: keep locked=0 → WAIT_LOCK timeouts at edges 24, 48, 72, with retry_cnt 1, 2 and then FAIL (fail=1, wiz_rst=1, state_dbg=4). State holds indefinitely.
3. Recovery from FAIL: pulse restart_req in FAIL, then drive locked=1 → RESET_WIZ next edge, retry_cnt=0, then a normal bring-up reaches RUN.
4. Lock drop during SETTLE: drop locked 3 cycles into SETTLE → RESET_WIZ with retry_cnt=1. Next attempt holds lock → RUN, retry_cnt returns to 0.
5. Lock loss in RUN: drop locked while in RUN → rst_n_out=0 and sys_ready=0 two edges after locked is sampled low, lock_loss_cnt=1, retry_cnt unchanged. Repeat 300 times → lock_loss_cnt=255.
6. Reset and priority: assert sys_rst=0 during SETTLE together with restart_req → all outputs return to reset values at the next edge. restart_req alone during RUN → RESET_WIZ, lock_loss_cnt unchanged.
